// File: rtl/m_calc_key_ctrl_pkg.sv
// Shared key codes, ALU op encodings and entry-FSM states for the calculator key sequencer.
package m_calc_key_ctrl_pkg;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_DIV = 4'hD;
   localparam logic [3:0] KEY_CLR = 4'hE;
   localparam logic [3:0] KEY_EQ  = 4'hF;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [2:0] {
      S_A   = 3'd0,
      S_OP  = 3'd1,
      S_B   = 3'd2,
      S_REQ = 3'd3,
      S_RES = 3'd4,
      S_ERR = 3'd5
   } state_e;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic is_oper(input logic [3:0] k);
      return (k >= KEY_ADD) && (k <= KEY_DIV);
   endfunction

   function automatic logic [1:0] key_to_op(input logic [3:0] k);
      logic [1:0] op;
      case (k)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         KEY_DIV: op = OP_DIV;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/m_calc_key_ctrl_debounce.sv
// Scan-rate key debouncer: one key_evt pulse per accepted press, re-armed only by a stable release.
module m_key_debounce #(
   parameter int DEB_SCANS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_tc,
   input  logic       pushed,
   input  logic [3:0] code,
   output logic       key_evt,
   output logic [3:0] key_code
);

   localparam int CW = $clog2(DEB_SCANS);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_SCANS - 1);

   logic [4:0]    prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q;
   logic          evt_q;
   logic [3:0]    code_q;
   logic [4:0]    sample;

   assign sample = {pushed, code};

   // Saturating stability counter so a long hold never wraps into a second press.
   always_comb begin
      cnt_d = '0;
      if (sample == prev_q) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b1;
         evt_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         evt_q <= 1'b0;
         if (scan_tc) begin
            prev_q <= sample;
            cnt_q  <= cnt_d;
            if (cnt_d == CNT_MAX) begin
               if (pushed && armed_q) begin
                  evt_q   <= 1'b1;
                  code_q  <= code;
                  armed_q <= 1'b0;
               end else if (!pushed) begin
                  armed_q <= 1'b1;
               end
            end
         end
      end
   end

   assign key_evt  = evt_q;
   assign key_code = code_q;

endmodule

// File: rtl/m_calc_key_ctrl.sv
// Calculator key sequencer: debounced key events drive BCD operand/operator entry and an ALU req/ack handshake.
module m_calc_key_ctrl
   import m_calc_key_ctrl_pkg::*;
#(
   parameter int NDIG      = 4,
   parameter int DEB_SCANS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scan_tc,
   input  logic                pushed,
   input  logic [3:0]          code,
   output logic                alu_req,
   output logic [1:0]          alu_op,
   output logic [4*NDIG-1:0]   alu_a,
   output logic [4*NDIG-1:0]   alu_b,
   input  logic                alu_ack,
   input  logic [4*NDIG-1:0]   alu_res,
   input  logic                alu_err,
   output logic [4*NDIG-1:0]   disp,
   output logic                disp_err,
   output logic                key_evt
);

   localparam int W = 4 * NDIG;

   state_e         state_q;
   logic [W-1:0]   a_q, b_q;
   logic [1:0]     op_q;
   logic           pend_vld_q;
   logic [1:0]     pend_op_q;
   logic           req_q;
   logic           kevt;
   logic [3:0]     kcode;
   logic           clr_evt;

   // Digits beyond NDIG significant places are dropped rather than shifted out.
   function automatic logic [W-1:0] shift_digit(input logic [W-1:0] v, input logic [3:0] d);
      if (v[W-1:W-4] != 4'd0) begin
         return v;
      end
      return {v[W-5:0], d};
   endfunction

   m_key_debounce #(
      .DEB_SCANS (DEB_SCANS)
   ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .scan_tc  (scan_tc),
      .pushed   (pushed),
      .code     (code),
      .key_evt  (kevt),
      .key_code (kcode)
   );

   assign clr_evt = kevt && (kcode == KEY_CLR);

   always_ff @(posedge clk) begin
      if (rst || clr_evt) begin
         state_q    <= S_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_ADD;
         pend_vld_q <= 1'b0;
         pend_op_q  <= OP_ADD;
         req_q      <= 1'b0;
      end else begin
         case (state_q)
            S_A: begin
               if (kevt && is_digit(kcode)) begin
                  a_q <= shift_digit(a_q, kcode);
               end else if (kevt && is_oper(kcode)) begin
                  op_q    <= key_to_op(kcode);
                  state_q <= S_OP;
               end
            end
            S_OP: begin
               if (kevt && is_oper(kcode)) begin
                  op_q <= key_to_op(kcode);
               end else if (kevt && is_digit(kcode)) begin
                  b_q     <= {{(W-4){1'b0}}, kcode};
                  state_q <= S_B;
               end
            end
            S_B: begin
               if (kevt && is_digit(kcode)) begin
                  b_q <= shift_digit(b_q, kcode);
               end else if (kevt && (kcode == KEY_EQ)) begin
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end else if (kevt && is_oper(kcode)) begin
                  pend_vld_q <= 1'b1;
                  pend_op_q  <= key_to_op(kcode);
                  req_q      <= 1'b1;
                  state_q    <= S_REQ;
               end
            end
            S_REQ: begin
               if (alu_ack) begin
                  req_q      <= 1'b0;
                  pend_vld_q <= 1'b0;
                  if (alu_err) begin
                     state_q <= S_ERR;
                  end else begin
                     a_q <= alu_res;
                     b_q <= '0;
                     if (pend_vld_q) begin
                        op_q    <= pend_op_q;
                        state_q <= S_OP;
                     end else begin
                        state_q <= S_RES;
                     end
                  end
               end
            end
            S_RES: begin
               if (kevt && is_digit(kcode)) begin
                  a_q     <= {{(W-4){1'b0}}, kcode};
                  state_q <= S_A;
               end else if (kevt && is_oper(kcode)) begin
                  op_q    <= key_to_op(kcode);
                  state_q <= S_OP;
               end
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q <= S_A;
            end
         endcase
      end
   end

   always_comb begin
      disp = a_q;
      case (state_q)
         S_B, S_REQ: disp = b_q;
         S_ERR:      disp = '0;
         default:    disp = a_q;
      endcase
   end

   assign disp_err = (state_q == S_ERR);
   assign alu_req  = req_q;
   assign alu_op   = op_q;
   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign key_evt  = kevt;

endmodule

// File: tb/tb_m_calc_key_ctrl.sv
// Directed bench for the calculator key sequencer: debounce, entry, chaining, errors, reset/clear.
module tb_m_calc_key_ctrl;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic         clk     = 1'b0;
   logic         rst     = 1'b1;
   logic         scan_tc = 1'b0;
   logic         pushed  = 1'b0;
   logic [3:0]   code    = 4'h0;
   logic         alu_ack = 1'b0;
   logic [W-1:0] alu_res = '0;
   logic         alu_err = 1'b0;
   logic         alu_req;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] disp;
   logic         disp_err;
   logic         key_evt;

   int n_checks = 0;
   int n_fail   = 0;
   int evt_cnt  = 0;
   int e0       = 0;

   m_calc_key_ctrl #(
      .NDIG      (NDIG),
      .DEB_SCANS (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .scan_tc  (scan_tc),
      .pushed   (pushed),
      .code     (code),
      .alu_req  (alu_req),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ack  (alu_ack),
      .alu_res  (alu_res),
      .alu_err  (alu_err),
      .disp     (disp),
      .disp_err (disp_err),
      .key_evt  (key_evt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (key_evt) evt_cnt <= evt_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic p, input logic [3:0] c);
      pushed  = p;
      code    = c;
      scan_tc = 1'b1;
      tick();
      scan_tc = 1'b0;
      pushed  = 1'b0;
      code    = 4'h0;
   endtask

   task automatic press(input logic [3:0] k);
      repeat (3) scan(1'b1, k);
      repeat (3) scan(1'b0, 4'h0);
   endtask

   task automatic ack(input logic [W-1:0] r, input logic e);
      alu_res = r;
      alu_err = e;
      alu_ack = 1'b1;
      tick();
      alu_ack = 1'b0;
      alu_err = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("rst_req",   32'(alu_req),  0);
      chk("rst_disp",  32'(disp),     0);
      chk("rst_err",   32'(disp_err), 0);
      chk("rst_evt",   32'(key_evt),  0);
      chk("rst_a",     32'(alu_a),    0);
      chk("rst_op",    32'(alu_op),   0);

      // debounce: hold 7 for five scans
      e0 = evt_cnt;
      scan(1'b1, 4'h7);
      scan(1'b1, 4'h7);
      chk("evt_early", 32'(key_evt), 0);
      scan(1'b1, 4'h7);
      chk("evt_at3",   32'(key_evt), 1);
      scan(1'b1, 4'h7);
      chk("evt_4th",   32'(key_evt), 0);
      scan(1'b1, 4'h7);
      repeat (3) scan(1'b0, 4'h0);
      chk("evt_count", 32'(evt_cnt - e0), 1);
      chk("deb_disp",  32'(disp), 'h0007);

      // bounce 7,(none),7,7,7
      e0 = evt_cnt;
      scan(1'b1, 4'h7);
      scan(1'b0, 4'h0);
      scan(1'b1, 4'h7);
      scan(1'b1, 4'h7);
      scan(1'b1, 4'h7);
      repeat (3) scan(1'b0, 4'h0);
      chk("bounce_cnt",  32'(evt_cnt - e0), 1);
      chk("bounce_disp", 32'(disp), 'h0077);
      press(4'hE);
      chk("clr_disp",    32'(disp), 0);

      // entry saturation
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
      chk("entry_disp", 32'(disp), 'h1234);
      press(4'hE);

      // add 12+34
      press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hF);
      chk("add_req",  32'(alu_req), 1);
      chk("add_a",    32'(alu_a),   'h0012);
      chk("add_b",    32'(alu_b),   'h0034);
      chk("add_op",   32'(alu_op),  0);
      chk("add_disp", 32'(disp),    'h0034);
      press(4'h9);
      chk("req_hold_b",   32'(alu_b),   'h0034);
      chk("req_hold_req", 32'(alu_req), 1);
      ack(16'h0046, 1'b0);
      chk("add_req_drop", 32'(alu_req), 0);
      chk("add_res",      32'(disp),    'h0046);
      press(4'h5);
      chk("res_digit",    32'(disp),    'h0005);
      press(4'hE);

      // chain 9-4*3
      press(4'h9); press(4'hB); press(4'h4); press(4'hC);
      chk("ch_req", 32'(alu_req), 1);
      chk("ch_a",   32'(alu_a),   'h0009);
      chk("ch_b",   32'(alu_b),   'h0004);
      chk("ch_op",  32'(alu_op),  1);
      ack(16'h0005, 1'b0);
      chk("ch_req_drop", 32'(alu_req), 0);
      chk("ch_disp",     32'(disp),    'h0005);
      chk("ch_op2",      32'(alu_op),  2);
      press(4'h3); press(4'hF);
      chk("ch2_req", 32'(alu_req), 1);
      chk("ch2_a",   32'(alu_a),   'h0005);
      chk("ch2_b",   32'(alu_b),   'h0003);
      chk("ch2_op",  32'(alu_op),  2);
      ack(16'h0015, 1'b0);
      chk("ch2_disp", 32'(disp), 'h0015);
      press(4'hE);

      // divide by zero
      press(4'h5); press(4'hD); press(4'h0); press(4'hF);
      chk("div_req", 32'(alu_req), 1);
      chk("div_op",  32'(alu_op),  3);
      ack(16'h0000, 1'b1);
      chk("err_flag", 32'(disp_err), 1);
      chk("err_disp", 32'(disp),     0);
      chk("err_req",  32'(alu_req),  0);
      press(4'h7);
      chk("err_ign_flag", 32'(disp_err), 1);
      chk("err_ign_disp", 32'(disp),     0);
      press(4'hE);
      chk("err_clr_flag", 32'(disp_err), 0);
      chk("err_clr_disp", 32'(disp),     0);

      // reset mid-request
      press(4'h1); press(4'hA); press(4'h2); press(4'hF);
      chk("rq_req", 32'(alu_req), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rq_rst_req",  32'(alu_req), 0);
      chk("rq_rst_disp", 32'(disp),    0);
      ack(16'h0099, 1'b0);
      chk("rq_late_disp", 32'(disp),  0);
      chk("rq_late_a",    32'(alu_a), 0);
      press(4'h3);
      chk("rq_after", 32'(disp), 'h0003);
      press(4'hE);

      // clear coincident with ack
      press(4'h1); press(4'hA); press(4'h2); press(4'hF);
      chk("cq_req", 32'(alu_req), 1);
      repeat (3) scan(1'b1, 4'hE);
      chk("cq_evt", 32'(key_evt), 1);
      ack(16'h0077, 1'b0);
      chk("cq_req_drop", 32'(alu_req), 0);
      chk("cq_disp",     32'(disp),    0);
      chk("cq_a",        32'(alu_a),   0);
      repeat (3) scan(1'b0, 4'h0);
      press(4'h4);
      chk("cq_after", 32'(disp), 'h0004);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
